// File: rtl/ast_demux_buf.sv
// Packet demux: routes whole Avalon-ST packets to one of TX_DIR outputs via 2-entry buffers (optional AST_DEMUX_DROP_BAD_DIR_EN).
// Latency: 1 cycle from accepted input beat to the output; 1 beat/cycle per stream.
// Backpressure: ast_ready_o falls when the target buffer is full; other directions drain independently.
module ast_demux_buf #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_W     = 10,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR)
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [DATA_WIDTH-1:0]                ast_data_i,
    input  logic                                 ast_startofpacket_i,
    input  logic                                 ast_endofpacket_i,
    input  logic                                 ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]               ast_empty_i,
    input  logic [CHANNEL_W-1:0]                 ast_channel_i,
    input  logic [DIR_SEL_WIDTH-1:0]             dir_i,
    output logic                                 ast_ready_o,
    output logic [TX_DIR-1:0][DATA_WIDTH-1:0]    ast_data_o,
    output logic [TX_DIR-1:0]                    ast_startofpacket_o,
    output logic [TX_DIR-1:0]                    ast_endofpacket_o,
    output logic [TX_DIR-1:0]                    ast_valid_o,
    output logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [TX_DIR-1:0][CHANNEL_W-1:0]     ast_channel_o,
    input  logic [TX_DIR-1:0]                    ast_ready_i
`ifdef AST_DEMUX_DROP_BAD_DIR_EN
    ,
    output logic [15:0]                          bad_pkt_cnt_o
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PKT  = 1'b1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [CHANNEL_W-1:0]   channel;
    } beat_t;

    logic [0:0]               state;
    logic [DIR_SEL_WIDTH-1:0] cur_dir;
    logic [DIR_SEL_WIDTH-1:0] dir_sel;
    logic [DIR_SEL_WIDTH-1:0] tgt;
    logic                     cur_bad;
    logic                     bad_sop;
    logic                     drop;
    logic                     accept;
    logic [TX_DIR-1:0]        push;
    logic [TX_DIR-1:0]        pop;
    logic [TX_DIR-1:0]        rd_ptr;
    logic [TX_DIR-1:0]        wr_ptr;
    logic [TX_DIR-1:0][1:0]   cnt;
    beat_t                    mem [TX_DIR][2];
    beat_t                    in_beat;

`ifdef AST_DEMUX_DROP_BAD_DIR_EN
    assign bad_sop = (32'(dir_i) >= TX_DIR);
`else
    assign bad_sop = 1'b0;
`endif

    assign in_beat = '{data: ast_data_i, sop: ast_startofpacket_i, eop: ast_endofpacket_i,
                       empty: ast_empty_i, channel: ast_channel_i};

    // Out-of-range selects wrap modulo TX_DIR; in drop mode those packets never push.
    always_comb begin
        dir_sel     = ast_startofpacket_i ? dir_i : cur_dir;
        tgt         = DIR_SEL_WIDTH'(32'(dir_sel) % TX_DIR);
        drop        = ast_startofpacket_i ? bad_sop : ((state == IDLE) || cur_bad);
        ast_ready_o = !srst_i && (drop || (cnt[tgt] != 2'd2));
        accept      = ast_valid_i && ast_ready_o;
        push        = '0;
        for (int d = 0; d < TX_DIR; d++) begin
            push[d] = accept && !drop && (tgt == DIR_SEL_WIDTH'(d));
        end
        pop = ast_valid_o & ast_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state   <= IDLE;
            cur_dir <= '0;
            cur_bad <= 1'b0;
        end else if (accept) begin
            if (ast_startofpacket_i) begin
                cur_dir <= dir_i;
                cur_bad <= bad_sop;
                state   <= ast_endofpacket_i ? IDLE : PKT;
            end else if ((state == PKT) && ast_endofpacket_i) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int d = 0; d < TX_DIR; d++) begin
                mem[d][0] <= '0;
                mem[d][1] <= '0;
            end
        end else begin
            for (int d = 0; d < TX_DIR; d++) begin
                if (push[d]) begin
                    mem[d][wr_ptr[d]] <= in_beat;
                    wr_ptr[d]         <= ~wr_ptr[d];
                end
                if (pop[d]) begin
                    rd_ptr[d] <= ~rd_ptr[d];
                end
                cnt[d] <= cnt[d] + {1'b0, push[d]} - {1'b0, pop[d]};
            end
        end
    end

    always_comb begin
        ast_data_o          = '0;
        ast_startofpacket_o = '0;
        ast_endofpacket_o   = '0;
        ast_valid_o         = '0;
        ast_empty_o         = '0;
        ast_channel_o       = '0;
        for (int d = 0; d < TX_DIR; d++) begin
            ast_data_o[d]          = mem[d][rd_ptr[d]].data;
            ast_startofpacket_o[d] = mem[d][rd_ptr[d]].sop;
            ast_endofpacket_o[d]   = mem[d][rd_ptr[d]].eop;
            ast_empty_o[d]         = mem[d][rd_ptr[d]].empty;
            ast_channel_o[d]       = mem[d][rd_ptr[d]].channel;
            ast_valid_o[d]         = (cnt[d] != 2'd0);
        end
    end

`ifdef AST_DEMUX_DROP_BAD_DIR_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            bad_pkt_cnt_o <= '0;
        end else if (accept && ast_startofpacket_i && bad_sop && (bad_pkt_cnt_o != 16'hFFFF)) begin
            bad_pkt_cnt_o <= bad_pkt_cnt_o + 16'd1;
        end
    end
`endif

endmodule
